pipe_stage: RTL and testbench
=============================

# pipe_stage

Parametrised elastic pipeline stage register for the five-stage MIPS datapath, replacing the fixed-field D/E/M/W boundary registers with one generic block. It carries a WIDTH-bit payload across a stage boundary under a valid/ready handshake, holds data under back-pressure, and discards its contents on a pipeline flush (interrupt request or eret). An optional two-entry skid buffer gives a registered in_ready at full throughput.

## Interface
- WIDTH, 32: payload width in bits; the instantiating stage concatenates instr/PC/PC8/data/A3 fields into this payload.
- FLUSH_VAL, {WIDTH{1'b0}}: value driven on out_data while the stage is empty (all-zero, so instr reads as nop and A3 as $0).
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous flush (IntReq | eret from CP0); clears the stage.
- in_valid  input  1  upstream holds a valid payload.
- in_ready  output  1  stage accepts a payload this cycle.
- in_data  input  WIDTH  upstream payload.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts out_data this cycle.
- out_data  output  WIDTH  payload presented to the next stage.
- count  output  2  entries currently held (0..2; max 1 without skid).

## Operation
- Transfer in: in_valid & in_ready at a rising edge. Transfer out: out_valid & out_ready at a rising edge.
- Storage: main entry (drives out_data/out_valid) and, with skid, a skid entry.
- States: EMPTY (count 0), ONE (main valid), TWO (main + skid valid; skid build only).
- EMPTY: in transfer -> ONE, main <= in_data.
- ONE: in only -> TWO (skid build, skid <= in_data) / stays ONE without skid only if out transfer also occurs; out only -> EMPTY; in and out -> ONE, main <= in_data.
- TWO: out transfer -> ONE, main <= skid; in_ready is 0 so no in transfer.
- Order preserved strictly FIFO; no payload duplicated or dropped except by flush.
- Flush: highest priority over every transfer. Next state EMPTY; an in transfer coincident with flush is discarded; an out transfer coincident with flush still completes (downstream sampled it) but nothing else is retained.
- While EMPTY, out_data = FLUSH_VAL; out_valid = 0.
- Downstream must not depend on out_data when out_valid = 0 except as a nop.

## Timing
- Reset (reset = 0, asynchronous): state EMPTY, out_valid 0, out_data FLUSH_VAL, count 0, skid cleared; in_ready 1 immediately.
- Latency: payload accepted at edge N appears on out_data after edge N (one cycle), unless older entries are queued ahead.
- out_valid, out_data, count are registered outputs.
- in_ready (skid build) = !skid_valid, registered, no combinational path from out_ready.
- in_ready (no skid) = !main_valid | out_ready, combinational from out_ready.
- Throughput: one payload per cycle sustained when out_ready = 1 in both builds.
- Flush asserted at edge N: out_valid 0 and out_data FLUSH_VAL after edge N; in_ready 1 after edge N.
- Reset release mid-stream: first transfer possible on the first edge with reset = 1.

## Configuration
- PIPE_STAGE_SKID_EN defined: two-entry skid buffer, states EMPTY/ONE/TWO, registered in_ready, count 0..2.
- Undefined: single entry, states EMPTY/ONE only, combinational in_ready as above, count 0..1 (bit 1 tied 0); skid register absent.

## Test plan
- Reset with reset = 0 mid-transfer, in_data = 0x12345678 -> out_valid 0, out_data 0, count 0, in_ready 1 without waiting for a clock edge.
- Stream 0x1..0x8, in_valid and out_ready held 1 -> out_data 0x1..0x8 on consecutive cycles, one cycle behind input, count constant 1.
- Skid build: out_ready = 0 while sending 0xA, 0xB, 0xC -> 0xA, 0xB held, count 2, in_ready 0, 0xC not accepted; raise out_ready -> outputs 0xA, 0xB, then 0xC in order.
- Flush with count 2 and in_valid = 1 (0xD) -> next cycle out_valid 0, out_data 0, count 0; 0xD never appears.
- Flush and stall together (flush = 1, out_ready = 0, count 1) -> EMPTY next cycle; flush wins over hold.
- No-skid build, count 1, out_ready toggling 1,0,1 with in_valid = 1 -> in_ready tracks out_ready combinationally; no payload lost or duplicated.

Source files
------------

// File: rtl/pipe_stage_if.sv
// Handshake bundle for one pipeline stage boundary: upstream side, downstream side and occupancy.
// The "slave" modport is the stage itself; "master" is whoever surrounds it (neighbour stages or a bench).
interface pipe_stage_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       count;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, count
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, count
    );
endinterface

// File: rtl/pipe_stage.sv
// Elastic valid/ready stage register for the MIPS D/E/M/W boundaries; optional skid buffer via PIPE_STAGE_SKID_EN.
// Latency: one cycle from in transfer to out_data (more only when older entries are queued ahead).
// Backpressure: skid build holds two entries with a registered in_ready; default build stalls via in_ready = !main_vld | out_ready.
module pipe_stage #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] FLUSH_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    pipe_stage_if.slave  bus
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t           state;
    logic             main_vld;
    logic [WIDTH-1:0] main_dat;
    logic             in_xfer;
    logic             out_xfer;

    assign in_xfer      = bus.in_valid & bus.in_ready;
    assign out_xfer     = main_vld & bus.out_ready;
    assign bus.out_valid = main_vld;
    assign bus.out_data  = main_dat;

`ifdef PIPE_STAGE_SKID_EN
    logic             skid_vld;
    logic [WIDTH-1:0] skid_dat;
    logic             in_rdy_q;
    logic [1:0]       cnt;

    // in_ready is its own flop so upstream never sees a path from out_ready.
    assign bus.in_ready = in_rdy_q;
    assign bus.count    = cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= EMPTY;
            main_vld <= 1'b0;
            main_dat <= FLUSH_VAL;
            skid_vld <= 1'b0;
            skid_dat <= '0;
            in_rdy_q <= 1'b1;
            cnt      <= 2'd0;
        end else if (flush) begin
            state    <= EMPTY;
            main_vld <= 1'b0;
            main_dat <= FLUSH_VAL;
            skid_vld <= 1'b0;
            skid_dat <= '0;
            in_rdy_q <= 1'b1;
            cnt      <= 2'd0;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_xfer) begin
                        state    <= ONE;
                        main_vld <= 1'b1;
                        main_dat <= bus.in_data;
                        cnt      <= 2'd1;
                    end
                end
                ONE: begin
                    if (in_xfer && out_xfer) begin
                        main_dat <= bus.in_data;
                    end else if (in_xfer) begin
                        state    <= TWO;
                        skid_vld <= 1'b1;
                        skid_dat <= bus.in_data;
                        in_rdy_q <= 1'b0;
                        cnt      <= 2'd2;
                    end else if (out_xfer) begin
                        state    <= EMPTY;
                        main_vld <= 1'b0;
                        main_dat <= FLUSH_VAL;
                        cnt      <= 2'd0;
                    end
                end
                TWO: begin
                    if (out_xfer) begin
                        state    <= ONE;
                        main_dat <= skid_dat;
                        skid_vld <= 1'b0;
                        in_rdy_q <= 1'b1;
                        cnt      <= 2'd1;
                    end
                end
                default: begin
                    state    <= EMPTY;
                    main_vld <= 1'b0;
                    main_dat <= FLUSH_VAL;
                    skid_vld <= 1'b0;
                    in_rdy_q <= 1'b1;
                    cnt      <= 2'd0;
                end
            endcase
        end
    end
`else
    logic cnt_lo;

    assign bus.in_ready = ~main_vld | bus.out_ready;
    assign bus.count    = {1'b0, cnt_lo};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= EMPTY;
            main_vld <= 1'b0;
            main_dat <= FLUSH_VAL;
            cnt_lo   <= 1'b0;
        end else if (flush) begin
            state    <= EMPTY;
            main_vld <= 1'b0;
            main_dat <= FLUSH_VAL;
            cnt_lo   <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_xfer) begin
                        state    <= ONE;
                        main_vld <= 1'b1;
                        main_dat <= bus.in_data;
                        cnt_lo   <= 1'b1;
                    end
                end
                ONE: begin
                    // With a single entry an in transfer here implies an out transfer too.
                    if (out_xfer) begin
                        if (in_xfer) begin
                            main_dat <= bus.in_data;
                        end else begin
                            state    <= EMPTY;
                            main_vld <= 1'b0;
                            main_dat <= FLUSH_VAL;
                            cnt_lo   <= 1'b0;
                        end
                    end
                end
                default: begin
                    state    <= EMPTY;
                    main_vld <= 1'b0;
                    main_dat <= FLUSH_VAL;
                    cnt_lo   <= 1'b0;
                end
            endcase
        end
    end
`endif
endmodule

// File: tb/tb_pipe_stage.sv
// Bench for pipe_stage: directed scenarios plus random traffic, all checked against a queue model of the stage.
module tb_pipe_stage;
    localparam int W = 32;
`ifdef PIPE_STAGE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic clk;
    logic reset;
    logic flush;

    pipe_stage_if #(.WIDTH(W)) bif ();

    pipe_stage #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    logic [W-1:0] q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive inputs, compare against the model mid-cycle, then advance model and clock.
    task automatic step(input logic f, input logic iv, input logic [W-1:0] d,
                        input logic ordy, output logic acc);
        logic exp_rdy;
        flush         = f;
        bif.in_valid  = iv;
        bif.in_data   = d;
        bif.out_ready = ordy;
        @(negedge clk);
        exp_rdy = SKID ? (q.size() < 2) : (q.size() == 0 || ordy);
        check("in_ready",  bif.in_ready,  exp_rdy);
        check("out_valid", bif.out_valid, q.size() > 0);
        check("out_data",  bif.out_data,  (q.size() > 0) ? q[0] : '0);
        check("count",     bif.count,     q.size());
        acc = iv && exp_rdy && !f;
        if (f) begin
            q.delete();
        end else begin
            if (q.size() > 0 && ordy) void'(q.pop_front());
            if (iv && exp_rdy) q.push_back(d);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_out_valid"}, bif.out_valid, 1'b0);
        check({tag, "_out_data"},  bif.out_data,  '0);
        check({tag, "_count"},     bif.count,     2'd0);
        check({tag, "_in_ready"},  bif.in_ready,  1'b1);
    endtask

    initial begin
        logic acc;
        int   tries;
        reset         = 1'b0;
        flush         = 1'b0;
        bif.in_valid  = 1'b1;
        bif.in_data   = 32'h1234_5678;
        bif.out_ready = 1'b0;
        #2;
        check_reset_state("rst0");
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Full-rate streaming.
        for (int i = 1; i <= 8; i++) step(1'b0, 1'b1, W'(i), 1'b1, acc);
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, '0, 1'b1, acc);

        // Stall with three offered payloads, then drain with C held until accepted.
        step(1'b0, 1'b1, 32'hA, 1'b0, acc);
        step(1'b0, 1'b1, 32'hB, 1'b0, acc);
        if (!SKID) begin
            tries = 0;
            do begin
                step(1'b0, 1'b1, 32'hB, 1'b1, acc);
                tries++;
            end while (!acc && tries < 10);
            check("b_accepted", acc, 1'b1);
        end
        step(1'b0, 1'b1, 32'hC, 1'b0, acc);
        check("c_refused", acc, 1'b0);
        tries = 0;
        do begin
            step(1'b0, 1'b1, 32'hC, 1'b1, acc);
            tries++;
        end while (!acc && tries < 10);
        check("c_accepted", acc, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, 1'b1, acc);

        // Flush while full with a payload offered.
        step(1'b0, 1'b1, 32'hE, 1'b0, acc);
        step(1'b0, 1'b1, 32'hF, 1'b0, acc);
        step(1'b1, 1'b1, 32'hD, 1'b0, acc);
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, '0, 1'b1, acc);

        // Flush during a stall with one entry held.
        step(1'b0, 1'b1, 32'h7, 1'b0, acc);
        step(1'b1, 1'b0, '0, 1'b0, acc);
        step(1'b0, 1'b0, '0, 1'b0, acc);

        // out_ready toggling under continuous input.
        step(1'b0, 1'b1, 32'h21, 1'b1, acc);
        step(1'b0, 1'b1, 32'h22, 1'b1, acc);
        step(1'b0, 1'b1, 32'h23, 1'b0, acc);
        step(1'b0, 1'b1, 32'h24, 1'b1, acc);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, 1'b1, acc);

        // Asynchronous reset with data held, applied between clock edges.
        step(1'b0, 1'b1, 32'h55, 1'b0, acc);
        step(1'b0, 1'b1, 32'h66, 1'b0, acc);
        bif.in_valid = 1'b1;
        bif.in_data  = 32'h1234_5678;
        reset        = 1'b0;
        #2;
        check_reset_state("rst1");
        q.delete();
        @(posedge clk);
        #1;
        reset = 1'b1;
        step(1'b0, 1'b1, 32'h77, 1'b1, acc);
        check("post_reset_accept", acc, 1'b1);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(15) == 0), ($urandom_range(3) != 0), W'($urandom),
                 ($urandom_range(2) != 0), acc);
        end
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, 1'b1, acc);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
